// File: rtl/receive_pcs.sv
// receive_pcs: 1000BASE-X style receive PCS.
// Tracks the idle / start / data / end-of-packet sequence of 10-bit
// code-groups from the synchronizer and produces registered GMII-style
// RXD / RX_DV / RX_ER / receiving.  Code-group to octet decoding is done
// externally (dec_data / dec_valid arrive in the same cycle as SUDI).
// Optional feature: define RX_ERR_CNT_EN to add the saturating 8-bit
// receive-error counter output rx_err_cnt.
module receive_pcs #(
  parameter logic [7:0] SFD_BYTE = 8'h55
) (
  input  logic       rx_clk,
  input  logic       mr_main_reset,
  input  logic [9:0] SUDI,
  input  logic       rx_even,
  input  logic       code_sync_status,
  input  logic [7:0] dec_data,
  input  logic       dec_valid,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       receiving
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0] rx_err_cnt
`endif
);

  // Special code-groups, both running disparities (bit9 = a ... bit0 = j).
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] D162_N = 10'b0110110101;
  localparam logic [9:0] D162_P = 10'b1001000101;
  localparam logic [9:0] S_N    = 10'b1101101000;
  localparam logic [9:0] S_P    = 10'b0010010111;
  localparam logic [9:0] T_N    = 10'b1011101000;
  localparam logic [9:0] T_P    = 10'b0100010111;
  localparam logic [9:0] R_N    = 10'b1110101000;
  localparam logic [9:0] R_P    = 10'b0001010111;

  typedef enum logic [2:0] {
    LINK_FAILED,
    WAIT_FOR_K,
    RX_K,
    IDLE_D,
    RECEIVE,
    TRI,
    EPD_R
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] rxd_q, rxd_d;
  logic       dv_q, dv_d;
  logic       er_q, er_d;
  logic       recv_q, recv_d;

  logic is_k285, is_d162, is_s, is_t, is_r, k_even;

  // Classify the current code-group; a comma only counts on an even position.
  always_comb begin
    is_k285 = (SUDI == K285_N) || (SUDI == K285_P);
    is_d162 = (SUDI == D162_N) || (SUDI == D162_P);
    is_s    = (SUDI == S_N)    || (SUDI == S_P);
    is_t    = (SUDI == T_N)    || (SUDI == T_P);
    is_r    = (SUDI == R_N)    || (SUDI == R_P);
    k_even  = is_k285 && rx_even;
  end

  // Next state and next output values; everything idles unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    rxd_d   = 8'h00;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    recv_d  = 1'b0;
    if (!code_sync_status) begin
      // Loss of sync abandons everything silently: no error flag.
      state_d = LINK_FAILED;
    end else begin
      case (state_q)
        LINK_FAILED: begin
          state_d = WAIT_FOR_K;
        end
        WAIT_FOR_K: begin
          if (k_even) state_d = RX_K;
        end
        RX_K: begin
          if (is_d162) state_d = IDLE_D;
          else         state_d = WAIT_FOR_K;
        end
        IDLE_D: begin
          if (k_even) begin
            state_d = RX_K;
          end else if (is_s) begin
            state_d = RECEIVE;
            rxd_d   = SFD_BYTE;
            dv_d    = 1'b1;
            recv_d  = 1'b1;
          end else begin
            state_d = WAIT_FOR_K;
          end
        end
        RECEIVE: begin
          recv_d = 1'b1;
          if (is_t) begin
            // End of packet; receiving stays up until the /R/ check in TRI.
            state_d = TRI;
          end else if (k_even) begin
            // Comma inside a frame: frame cut short, flag it and resync on idle.
            state_d = RX_K;
            rxd_d   = dec_data;
            dv_d    = 1'b1;
            er_d    = 1'b1;
            recv_d  = 1'b0;
          end else if (dec_valid) begin
            rxd_d = dec_data;
            dv_d  = 1'b1;
          end else begin
            // Corrupt code-group: keep the frame open, mark this octet bad.
            rxd_d = dec_data;
            dv_d  = 1'b1;
            er_d  = 1'b1;
          end
        end
        TRI: begin
          if (is_r) begin
            state_d = EPD_R;
          end else begin
            state_d = WAIT_FOR_K;
            er_d    = 1'b1;
          end
        end
        EPD_R: begin
          if (k_even)    state_d = RX_K;
          else if (is_r) state_d = EPD_R;
          else           state_d = WAIT_FOR_K;
        end
        default: begin
          state_d = LINK_FAILED;
        end
      endcase
    end
  end

  // State and output registers; reset drops any frame in progress immediately.
  always_ff @(posedge rx_clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q <= LINK_FAILED;
      rxd_q   <= 8'h00;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      recv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rxd_q   <= rxd_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      recv_q  <= recv_d;
    end
  end

  assign RXD       = rxd_q;
  assign RX_DV     = dv_q;
  assign RX_ER     = er_q;
  assign receiving = recv_q;

`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Count one per cycle in which RX_ER is registered high; the count sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (er_d) err_cnt_d = sat_inc(err_cnt_q);
  end

  // Error counter register; only reset clears it.
  always_ff @(posedge rx_clk or negedge mr_main_reset) begin
    if (!mr_main_reset) err_cnt_q <= 8'h00;
    else                err_cnt_q <= err_cnt_d;
  end

  assign rx_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_receive_pcs.sv
// tb_receive_pcs: directed-vector bench for receive_pcs.
// Inputs change on the falling edge; outputs are checked 1 ns after the
// rising edge that registers them.
module tb_receive_pcs;

  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] D162_N = 10'b0110110101;
  localparam logic [9:0] D162_P = 10'b1001000101;
  localparam logic [9:0] S_N    = 10'b1101101000;
  localparam logic [9:0] S_P    = 10'b0010010111;
  localparam logic [9:0] T_N    = 10'b1011101000;
  localparam logic [9:0] T_P    = 10'b0100010111;
  localparam logic [9:0] R_N    = 10'b1110101000;
  localparam logic [9:0] R_P    = 10'b0001010111;
  localparam logic [9:0] DATA_CG = 10'b1001110100;  // any ordinary data code-group
  localparam logic [9:0] BAD_CG  = 10'b1111000011;  // not a valid code-group

  logic       rx_clk = 1'b0;
  logic       mr_main_reset = 1'b1;
  logic [9:0] SUDI = D162_N;
  logic       rx_even = 1'b0;
  logic       code_sync_status = 1'b1;
  logic [7:0] dec_data = 8'h00;
  logic       dec_valid = 1'b0;
  logic [7:0] RXD;
  logic       RX_DV;
  logic       RX_ER;
  logic       receiving;
`ifdef RX_ERR_CNT_EN
  logic [7:0] rx_err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  receive_pcs #(.SFD_BYTE(8'h55)) dut (
    .rx_clk          (rx_clk),
    .mr_main_reset   (mr_main_reset),
    .SUDI            (SUDI),
    .rx_even         (rx_even),
    .code_sync_status(code_sync_status),
    .dec_data        (dec_data),
    .dec_valid       (dec_valid),
    .RXD             (RXD),
    .RX_DV           (RX_DV),
    .RX_ER           (RX_ER),
    .receiving       (receiving)
`ifdef RX_ERR_CNT_EN
    ,
    .rx_err_cnt      (rx_err_cnt)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] rxd, input logic dv,
                            input logic er, input logic recv);
    check({tag, ".RXD"}, {24'h0, RXD}, {24'h0, rxd});
    check({tag, ".RX_DV"}, {31'h0, RX_DV}, {31'h0, dv});
    check({tag, ".RX_ER"}, {31'h0, RX_ER}, {31'h0, er});
    check({tag, ".receiving"}, {31'h0, receiving}, {31'h0, recv});
  endtask

  task automatic expect_cnt(input string tag, input logic [7:0] exp);
`ifdef RX_ERR_CNT_EN
    check({tag, ".cnt"}, {24'h0, rx_err_cnt}, {24'h0, exp});
`endif
  endtask

  // Present one code-group on the falling edge, return 1 ns after the rising edge.
  task automatic send(input logic [9:0] cg, input logic even, input logic [7:0] data = 8'h00,
                      input logic valid = 1'b0, input logic sync = 1'b1);
    @(negedge rx_clk);
    SUDI             = cg;
    rx_even          = even;
    dec_data         = data;
    dec_valid        = valid;
    code_sync_status = sync;
    @(posedge rx_clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset with no clock edge involved.
    #3 mr_main_reset = 1'b0;
    #1;
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    expect_cnt("reset", 8'h00);
    @(negedge rx_clk);
    mr_main_reset = 1'b1;  // next rising edge: LINK_FAILED -> WAIT_FOR_K

    // Idle, then frame 0x55 A1 B2 /T/ /R/ K28.5.
    send(K285_N, 1'b1);               expect_out("idle_k", 8'h00, 1'b0, 1'b0, 1'b0);
    send(D162_N, 1'b0);
    send(K285_P, 1'b1);
    send(D162_P, 1'b0);
    send(K285_N, 1'b1);
    send(D162_N, 1'b0);               expect_out("idle_d", 8'h00, 1'b0, 1'b0, 1'b0);
    send(S_N, 1'b1);                  expect_out("sfd", 8'h55, 1'b1, 1'b0, 1'b1);
    send(DATA_CG, 1'b0, 8'hA1, 1'b1); expect_out("byte_a1", 8'hA1, 1'b1, 1'b0, 1'b1);
    send(DATA_CG, 1'b1, 8'hB2, 1'b1); expect_out("byte_b2", 8'hB2, 1'b1, 1'b0, 1'b1);
    send(T_N, 1'b0);                  expect_out("eop_t", 8'h00, 1'b0, 1'b0, 1'b1);
    send(R_P, 1'b1);                  expect_out("eop_r", 8'h00, 1'b0, 1'b0, 1'b0);
    send(K285_N, 1'b1);               expect_out("end_k", 8'h00, 1'b0, 1'b0, 1'b0);
    // Ended in RX_K: D16.2 then /S/ opens a new frame.
    send(D162_N, 1'b0);
    send(S_P, 1'b1);                  expect_out("sfd2", 8'h55, 1'b1, 1'b0, 1'b1);

    // Invalid code-group mid-frame, then early end by comma.
    send(DATA_CG, 1'b0, 8'h11, 1'b1); expect_out("byte_11", 8'h11, 1'b1, 1'b0, 1'b1);
    send(BAD_CG, 1'b1, 8'h77, 1'b0);  expect_out("bad_cg", 8'h77, 1'b1, 1'b1, 1'b1);
    expect_cnt("bad_cg", 8'd1);
    send(DATA_CG, 1'b0, 8'h22, 1'b1); expect_out("byte_22", 8'h22, 1'b1, 1'b0, 1'b1);
    send(K285_P, 1'b1);
    check("early.RX_DV", {31'h0, RX_DV}, 32'd1);
    check("early.RX_ER", {31'h0, RX_ER}, 32'd1);
    check("early.receiving", {31'h0, receiving}, 32'd0);
    expect_cnt("early", 8'd2);
    send(D162_P, 1'b0);               expect_out("early_d", 8'h00, 1'b0, 1'b0, 1'b0);
    send(S_N, 1'b1);                  expect_out("sfd3", 8'h55, 1'b1, 1'b0, 1'b1);

    // Sync loss mid-frame.
    send(DATA_CG, 1'b0, 8'h33, 1'b1); expect_out("byte_33", 8'h33, 1'b1, 1'b0, 1'b1);
    send(DATA_CG, 1'b1, 8'h44, 1'b1, 1'b0);
    expect_out("sync_loss", 8'h00, 1'b0, 1'b0, 1'b0);
    send(D162_N, 1'b0);               expect_out("relock", 8'h00, 1'b0, 1'b0, 1'b0);

    // /T/ followed by something other than /R/ flags one error cycle.
    send(K285_N, 1'b1);
    send(D162_N, 1'b0);
    send(S_N, 1'b1);
    send(DATA_CG, 1'b0, 8'h5A, 1'b1); expect_out("byte_5a", 8'h5A, 1'b1, 1'b0, 1'b1);
    send(T_P, 1'b1);                  expect_out("tri", 8'h00, 1'b0, 1'b0, 1'b1);
    send(D162_N, 1'b0);               expect_out("tri_bad", 8'h00, 1'b0, 1'b1, 1'b0);
    expect_cnt("tri_bad", 8'd3);
    send(K285_N, 1'b1);               expect_out("tri_after", 8'h00, 1'b0, 1'b0, 1'b0);

    // IDLE_D with an unexpected code-group falls back to WAIT_FOR_K, so /S/ is ignored.
    send(D162_N, 1'b0);
    send(R_N, 1'b1);
    send(S_N, 1'b0);                  expect_out("idle_other", 8'h00, 1'b0, 1'b0, 0);

    // EPD_R holds on repeated /R/ and leaves to RX_K on comma.
    send(K285_N, 1'b1);
    send(D162_N, 1'b0);
    send(S_P, 1'b1);
    send(T_N, 1'b0);
    send(R_N, 1'b1);
    send(R_P, 1'b0);                  expect_out("epd_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    send(K285_P, 1'b1);
    send(D162_P, 1'b0);
    send(S_N, 1'b1);                  expect_out("epd_exit", 8'h55, 1'b1, 1'b0, 1'b1);

    // Reset between clock edges mid-frame.
    send(DATA_CG, 1'b0, 8'h66, 1'b1); expect_out("byte_66", 8'h66, 1'b1, 1'b0, 1'b1);
    #2 mr_main_reset = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    expect_cnt("async_rst", 8'd0);
    @(negedge rx_clk);
    @(posedge rx_clk);
    #1;
    expect_out("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge rx_clk);
    SUDI = D162_N; rx_even = 1'b0; dec_valid = 1'b0; code_sync_status = 1'b1;
    mr_main_reset = 1'b1;
    send(K285_N, 1'b1);
    send(D162_N, 1'b0);
    send(S_N, 1'b1);                  expect_out("post_rst", 8'h55, 1'b1, 1'b0, 1'b1);

    // Long run of bad code-groups.
    repeat (300) send(BAD_CG, 1'b0, 8'h0F, 1'b0);
    expect_out("err_run", 8'h0F, 1'b1, 1'b1, 1'b1);
    expect_cnt("err_run", 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
